reg_bank_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares a bank of NREG enable-gated W-bit registers between NREQ requesters.
- Each requester issues a single read or write; the block grants one requester at a time, drives the per-register write enable, returns read data and acknowledges.
- Sits between the lab's datapath clients and the register storage. It is the only writer of the bank.

---
 rtl/reg_bank_arbiter_pkg.sv | 21 ++
 rtl/reg_bank_arbiter_reg16_en.sv | 24 ++
 rtl/reg_bank_arbiter.sv | 160 ++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter: FSM state encoding,
// default geometry and a small helper for sizing the round-robin pointer.
package reg_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_NREG = 8;
  localparam int DEF_W    = 16;
  localparam int DEF_AW   = 3;

  // Width of an index that can name any of n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_reg16_en.sv
// One W-bit storage register of the bank: cleared by reset, loads d when en.
// Reset takes priority over a load in the same cycle.
module reg16_en #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage register with synchronous clear and enable-gated load.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter and sequencer owning a bank of NREG registers.
// Each granted transaction takes three cycles: IDLE (arbitrate and latch),
// BUSY (write or read the bank), DONE (ack pulse, no sampling).
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int NREG = DEF_NREG,
  parameter int W    = DEF_W,
  parameter int AW   = DEF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*W-1:0]  wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  ack,
  output logic [W-1:0]     rdata,
  output logic [NREG*W-1:0] bank_q
);

  localparam int PW = idx_width(NREQ);

  arb_state_t     state_r, state_n_s;
  logic [PW-1:0]  ptr_r, ptr_n_s;
  logic [NREQ-1:0] gnt_r, gnt_n_s;
  logic [NREQ-1:0] ack_r, ack_n_s;
  logic [W-1:0]   rdata_r, rdata_n_s;
  logic [PW-1:0]  lat_idx_r, lat_idx_n_s;
  logic           lat_we_r, lat_we_n_s;
  logic [AW-1:0]  lat_addr_r, lat_addr_n_s;
  logic [W-1:0]   lat_wdata_r, lat_wdata_n_s;
  logic [PW-1:0]  win_s;
  logic [W-1:0]   rd_mux_s;
  logic [NREG-1:0] wen_s;

  // First requester at or after p (wrapping) whose request bit is set.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   p);
    logic [PW-1:0] sel;
    logic [PW-1:0] cand;
    logic          found;
    sel   = {PW{1'b0}};
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(p) + k) % NREQ);
      if (!found && r[cand]) begin
        sel   = cand;
        found = 1'b1;
      end else begin
        sel   = sel;
      end
    end
    return sel;
  endfunction

  assign win_s = rr_pick(req, ptr_r);

  // Per-register write enable: only during BUSY of a write to that address.
  for (genvar r = 0; r < NREG; r++) begin : g_bank
    assign wen_s[r] = (state_r == ST_BUSY) && lat_we_r && (lat_addr_r == AW'(r));

    reg16_en #(.W(W)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (wen_s[r]),
      .d   (lat_wdata_r),
      .q   (bank_q[r*W +: W])
    );
  end

  // Read mux over the bank; addresses with no register read as zero.
  always_comb begin
    rd_mux_s = {W{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      if (lat_addr_r == AW'(r)) begin
        rd_mux_s = bank_q[r*W +: W];
      end else begin
        rd_mux_s = rd_mux_s;
      end
    end
  end

  // Next-state and next-output logic of the transaction sequencer.
  always_comb begin
    state_n_s     = state_r;
    ptr_n_s       = ptr_r;
    gnt_n_s       = gnt_r;
    ack_n_s       = {NREQ{1'b0}};
    rdata_n_s     = rdata_r;
    lat_idx_n_s   = lat_idx_r;
    lat_we_n_s    = lat_we_r;
    lat_addr_n_s  = lat_addr_r;
    lat_wdata_n_s = lat_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_n_s     = ST_BUSY;
          gnt_n_s       = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
          lat_idx_n_s   = win_s;
          lat_we_n_s    = we[win_s];
          lat_addr_n_s  = addr[win_s*AW +: AW];
          lat_wdata_n_s = wdata[win_s*W +: W];
        end else begin
          gnt_n_s       = {NREQ{1'b0}};
        end
      end
      ST_BUSY: begin
        if (!lat_we_r) begin
          rdata_n_s = rd_mux_s;
        end else begin
          rdata_n_s = rdata_r;
        end
        ack_n_s   = gnt_r;
        ptr_n_s   = (lat_idx_r == PW'(NREQ-1)) ? {PW{1'b0}} : lat_idx_r + PW'(1);
        state_n_s = ST_DONE;
      end
      ST_DONE: begin
        gnt_n_s   = {NREQ{1'b0}};
        state_n_s = ST_IDLE;
      end
      default: begin
        gnt_n_s   = {NREQ{1'b0}};
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, pointer, latched transaction and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {PW{1'b0}};
      gnt_r       <= {NREQ{1'b0}};
      ack_r       <= {NREQ{1'b0}};
      rdata_r     <= {W{1'b0}};
      lat_idx_r   <= {PW{1'b0}};
      lat_we_r    <= 1'b0;
      lat_addr_r  <= {AW{1'b0}};
      lat_wdata_r <= {W{1'b0}};
    end else begin
      state_r     <= state_n_s;
      ptr_r       <= ptr_n_s;
      gnt_r       <= gnt_n_s;
      ack_r       <= ack_n_s;
      rdata_r     <= rdata_n_s;
      lat_idx_r   <= lat_idx_n_s;
      lat_we_r    <= lat_we_n_s;
      lat_addr_r  <= lat_addr_n_s;
      lat_wdata_r <= lat_wdata_n_s;
    end
  end

  assign gnt   = gnt_r;
  assign ack   = ack_r;
  assign rdata = rdata_r;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: a transaction-level reference model predicts
// grants, ack slots, read data and bank contents; a monitor compares them
// against the DUT on every falling edge.
module tb_reg_bank_arbiter;

  localparam int NREQ = 4;
  localparam int NREG = 8;
  localparam int W    = 16;
  localparam int AW   = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*W-1:0]  wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic [W-1:0]       rdata;
  logic [NREG*W-1:0]  bank_q;

  reg_bank_arbiter #(.NREQ(NREQ), .NREG(NREG), .W(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .bank_q(bank_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] ack;
  } exp_t;

  exp_t            sb_q[$];
  logic [NREQ-1:0] ack_log[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // Reference model: a transaction slot is 3 cycles (arbitrate, access, ack).
  int              m_phase = 0;
  int              m_ptr   = 0;
  int              m_win   = 0;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [W-1:0]    m_wd;
  logic [NREQ-1:0] m_gnt   = '0;
  logic [W-1:0]    m_rdata = '0;
  logic [W-1:0]    m_bank[NREG];
  bit              done_flag;
  int              done_idx;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock and update the model with the inputs seen at that edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    done_flag = 1'b0;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_gnt = '0; m_rdata = '0;
      for (int r = 0; r < NREG; r++) m_bank[r] = '0;
    end else if (m_phase == 0) begin
      if (req != '0) begin
        for (int k = NREQ - 1; k >= 0; k--)
          if (req[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
        m_we    = we[m_win];
        m_addr  = addr[m_win*AW +: AW];
        m_wd    = wdata[m_win*W +: W];
        m_gnt   = '0;
        m_gnt[m_win] = 1'b1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m_we) m_bank[m_addr] = m_wd;
      else      m_rdata = m_bank[m_addr];
      e.cyc = cyc;
      e.ack = m_gnt;
      sb_q.push_back(e);
      m_ptr   = (m_win + 1) % NREQ;
      m_phase = 2;
    end else begin
      m_gnt     = '0;
      m_phase   = 0;
      done_flag = 1'b1;
      done_idx  = m_win;
    end
    #1;
  endtask

  task automatic wait_done(input int idx, input int budget);
    for (int t = 0; t < budget; t++) begin
      step();
      if (done_flag && done_idx == idx) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL timeout waiting for requester %0d completion", idx);
  endtask

  task automatic set_txn(input int i, input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW] = a;
    wdata[i*W +: W]  = d;
  endtask

  // Monitor: ack slots from the scoreboard, plus gnt/rdata/bank every cycle.
  always @(negedge clk) begin
    logic [NREG*W-1:0] flat;
    exp_t e;
    if (mon_en) begin
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        check("ack", ack, e.ack);
      end else begin
        check("no_ack", ack, '0);
      end
      if (ack != '0) ack_log.push_back(ack);
      check("gnt", gnt, m_gnt);
      check("rdata", rdata, m_rdata);
      for (int r = 0; r < NREG; r++) flat[r*W +: W] = m_bank[r];
      check("bank_q", bank_q, flat);
    end
  end

  initial begin
    logic [NREQ-1:0] exp_order[5];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    step();
    mon_en = 1'b1;
    step();
    check("reset_gnt", gnt, '0);
    check("reset_rdata", rdata, '0);
    check("reset_bank", bank_q, '0);
    rst = 1'b0;

    // Write then read from requester 1.
    set_txn(1, 1'b1, 3'd5, 16'hA5C3);
    wait_done(1, 10);
    we[1] = 1'b0;
    wait_done(1, 10);
    req[1] = 1'b0;
    check("wr_rd_rdata", rdata, 16'hA5C3);
    check("wr_rd_bank5", bank_q[5*W +: W], 16'hA5C3);

    // Pointer now at 2: requester 3 beats requester 0.
    ack_log.delete();
    set_txn(3, 1'b1, 3'd6, 16'h3333);
    set_txn(0, 1'b1, 3'd7, 16'h0777);
    wait_done(3, 10);
    req[3] = 1'b0;
    wait_done(0, 10);
    req[0] = 1'b0;
    check("rot_count", ack_log.size(), 2);
    if (ack_log.size() >= 2) begin
      check("rot_first", ack_log[0], 4'b1000);
      check("rot_second", ack_log[1], 4'b0001);
    end

    // Fairness: all four held from reset, each writing its index to addr 0.
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_txn(i, 1'b1, 3'd0, W'(i));
    step(); step();
    rst = 1'b0;
    ack_log.delete();
    begin
      int dones = 0;
      for (int t = 0; t < 40 && dones < 5; t++) begin
        step();
        if (done_flag) dones++;
      end
      req = '0;
      check("fair_dones", dones, 5);
    end
    check("fair_count", ack_log.size(), 5);
    for (int k = 0; k < 5 && k < ack_log.size(); k++)
      check("fair_order", ack_log[k], exp_order[k]);
    check("fair_bank0", bank_q[W-1:0], 16'h0000);

    // Reset during BUSY discards the write and clears the pointer.
    ack_log.delete();
    set_txn(2, 1'b1, 3'd1, 16'h1234);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req[2] = 1'b0;
    step(); step(); step();
    check("rst_mid_bank1", bank_q[1*W +: W], 16'h0000);
    check("rst_mid_noack", ack_log.size(), 0);
    set_txn(0, 1'b0, 3'd0, 16'h0000);
    set_txn(3, 1'b0, 3'd0, 16'h0000);
    wait_done(0, 10);
    req[0] = 1'b0;
    wait_done(3, 10);
    req[3] = 1'b0;
    check("rst_ptr_first", (ack_log.size() > 0) ? ack_log[0] : 4'b0000, 4'b0001);

    // Changes to wdata/addr while BUSY are ignored.
    set_txn(0, 1'b1, 3'd2, 16'h1111);
    step();
    wdata[0*W +: W] = 16'hFFFF;
    addr[0*AW +: AW] = 3'd3;
    wait_done(0, 10);
    req[0] = 1'b0;
    check("ign_bank2", bank_q[2*W +: W], 16'h1111);
    check("ign_bank3", bank_q[3*W +: W], 16'h0000);

    // Randomized traffic with occasional mid-flight input changes and resets.
    for (int t = 0; t < 600; t++) begin
      step();
      if (done_flag) begin
        if ($urandom_range(0, 1) == 1)
          set_txn(done_idx, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)), W'($urandom));
        else
          req[done_idx] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 3) == 0)
          set_txn(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)), W'($urandom));
      if (m_phase == 1 && $urandom_range(0, 2) == 0)
        wdata[m_win*W +: W] = W'($urandom);
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
    req = '0;
    for (int t = 0; t < 6; t++) step();
    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
